i2c_slave_byte_ctrl: RTL

I2C responder (slave) that answers a fixed 7-bit address on a shared open-drain bus. It is the target side of the I2C master and register block, used in the same system both for loopback verification of the master and as an on-chip I2C peripheral front-end. It oversamples SCL/SDA on the system clock and detects START and STOP. It receives write bytes and ACKs them, and serialises read bytes that a local host supplies through a request/sample interface. No clock stretching.

---
 rtl/i2c_slave_byte_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_byte_ctrl.sv
// I2C target with a fixed 7-bit address: ACKs write bytes and serialises
// read bytes supplied by a local host. Pins are oversampled on Clk.
module i2c_slave_byte_ctrl #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Scl_i,
    input  logic       Sda_i,
    output logic       Sda_oen,
    output logic       Busy,
    output logic       Rw,
    output logic [7:0] Rx_data,
    output logic       Rx_valid,
    output logic       Tx_req,
    input  logic [7:0] Tx_data,
    output logic       Master_ack,
    output logic       Stop_det
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t     r_state;
    logic       r_scl_s1, r_scl_s2, r_scl_d;
    logic       r_sda_s1, r_sda_s2, r_sda_d;
    logic [7:0] r_sr;
    logic [3:0] r_cnt;

    logic w_rise, w_fall, w_start, w_stop, w_active;

    assign w_rise   = r_scl_s2 & ~r_scl_d;
    assign w_fall   = ~r_scl_s2 & r_scl_d;
    assign w_start  = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop   = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_active = (r_state != IDLE) && (r_state != IGNORE);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_scl_s1   <= 1'b1;
            r_scl_s2   <= 1'b1;
            r_scl_d    <= 1'b1;
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
            r_sda_d    <= 1'b1;
            r_state    <= IDLE;
            r_sr       <= 8'h00;
            r_cnt      <= 4'd0;
            Sda_oen    <= 1'b1;
            Busy       <= 1'b0;
            Rw         <= 1'b0;
            Rx_data    <= 8'h00;
            Rx_valid   <= 1'b0;
            Tx_req     <= 1'b0;
            Master_ack <= 1'b1;
            Stop_det   <= 1'b0;
        end else begin
            r_scl_s1 <= Scl_i;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= Sda_i;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
            Rx_valid <= 1'b0;
            Tx_req   <= 1'b0;
            Stop_det <= 1'b0;
            if (w_stop) begin
                r_state  <= IDLE;
                r_cnt    <= 4'd0;
                Sda_oen  <= 1'b1;
                Busy     <= 1'b0;
                Stop_det <= 1'b1;
            end else if (w_start) begin
                r_state <= ADDR;
                r_cnt   <= 4'd0;
                Sda_oen <= 1'b1;
                Busy    <= 1'b1;
            end else if (w_rise) begin
                r_sr <= {r_sr[6:0], r_sda_s2};
                if (w_active)
                    r_cnt <= r_cnt + 4'd1;
                case (r_state)
                    ADDR_ACK: if (r_cnt == 4'd8 && Rw) Tx_req <= 1'b1;
                    WR_DATA: begin
                        if (r_cnt == 4'd7) begin
                            Rx_data  <= {r_sr[6:0], r_sda_s2};
                            Rx_valid <= 1'b1;
                        end
                    end
                    RD_ACK: begin
                        if (r_cnt == 4'd8) begin
                            Master_ack <= r_sda_s2;
                            Tx_req     <= ~r_sda_s2;
                        end
                    end
                    default: ;
                endcase
            end else if (w_fall) begin
                case (r_state)
                    ADDR: begin
                        if (r_cnt == 4'd8) begin
                            if (r_sr[7:1] == SLAVE_ADDR) begin
                                Sda_oen <= 1'b0;
                                Rw      <= r_sr[0];
                                r_state <= ADDR_ACK;
                            end else begin
                                Sda_oen <= 1'b1;
                                r_state <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (r_cnt == 4'd9) begin
                            r_cnt <= 4'd0;
                            if (Rw) begin
                                r_sr    <= Tx_data;
                                Sda_oen <= Tx_data[7];
                                r_state <= RD_DATA;
                            end else begin
                                Sda_oen <= 1'b1;
                                r_state <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (r_cnt == 4'd8) begin
                            Sda_oen <= 1'b0;
                            r_state <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (r_cnt == 4'd9) begin
                            Sda_oen <= 1'b1;
                            r_cnt   <= 4'd0;
                            r_state <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        // sr shifts on every rise, so sr[7] is the next bit out
                        if (r_cnt == 4'd8) begin
                            Sda_oen <= 1'b1;
                            r_state <= RD_ACK;
                        end else begin
                            Sda_oen <= r_sr[7];
                        end
                    end
                    RD_ACK: begin
                        if (r_cnt == 4'd9) begin
                            r_cnt <= 4'd0;
                            if (!Master_ack) begin
                                r_sr    <= Tx_data;
                                Sda_oen <= Tx_data[7];
                                r_state <= RD_DATA;
                            end else begin
                                Sda_oen <= 1'b1;
                                r_state <= IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
